lsu_mem_master: RTL

//  Initiator side of the single-port word data memory: the core's load/store unit.

---
 rtl/lsu_mem_master_pkg.sv | 48 ++++
 rtl/lsu_mem_master_if.sv | 37 +++
 rtl/lsu_mem_master_align.sv | 44 ++++
 rtl/lsu_mem_master.sv | 118 +++++++++++
 4 files changed

// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store unit memory master: RV32I size codes,
// FSM state encoding, request legality and lane-extraction helpers.
package lsu_mem_master_pkg;

    // Word-index bits decoded by the attached data memory.
    localparam int LSU_MEM_AW = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    // A request is refused when the size code is not legal for its direction
    // or when the address is not naturally aligned for that size.
    function automatic logic lsu_req_err(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [7:0] lsu_byte_lane(input logic [31:0] word,
                                                 input logic [1:0] off);
        return word[{off, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] lsu_half_lane(input logic [31:0] word,
                                                  input logic hsel);
        return word[{hsel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core-side request/response handshake plus the word-memory port, bundled so
// the LSU (master) and its environment (slave) see matching directions.
interface lsu_mem_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_mem_master_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges a right-aligned byte/half into an existing word for stores.
module lsu_mem_master_align
    import lsu_mem_master_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = lsu_byte_lane(load_word_i, off_i);
    assign half_v = lsu_half_lane(load_word_i, off_i[1]);

    // Load extract: pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        load_data_o = 32'h0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data_o = {24'h0, byte_v};
            F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data_o = {16'h0, half_v};
            F3_W:    load_data_o = load_word_i;
            default: load_data_o = 32'h0;
        endcase
    end

    // Store merge: overwrite only the addressed lane of the previously read word.
    always_comb begin
        store_word_o = old_word_i;
        case (funct3_i)
            F3_B:    store_word_o[{off_i, 3'b000} +: 8]     = store_data_i[7:0];
            F3_H:    store_word_o[{off_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            default: store_word_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: accepts one request at a time, performs a
// single read, single write, or read-modify-write on the word memory, and
// returns one response per request.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    lsu_mem_master_if.master bus
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic [31:0] rdata_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        err_q;

    logic        req_err;
    logic        accept;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_err = lsu_req_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign accept  = bus.req_valid && (state_q == S_IDLE);

    lsu_mem_master_align u_align (
        .funct3_i     (f3_q),
        .off_i        (addr_q[1:0]),
        .load_word_i  (bus.mem_rdata),
        .old_word_i   (old_q),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outward signals; memory strobes depend on state only
    // so that reset removes them without waiting for a clock edge.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wdata  = 32'h0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err)
                        state_d = S_RESP;
                    else if (!bus.req_we || (bus.req_funct3 != F3_W))
                        state_d = S_READ;
                    else
                        state_d = S_WRITE;
                end
            end
            S_READ: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = {2'b00, addr_q[31:2]};
                state_d      = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {2'b00, addr_q[31:2]};
                bus.mem_wdata = store_word;
                state_d       = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture on accept; memory word and load result captured in READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            old_q   <= 32'h0;
            rdata_q <= 32'h0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            f3_q    <= bus.req_funct3;
            we_q    <= bus.req_we;
            err_q   <= req_err;
            rdata_q <= 32'h0;
        end else if (state_q == S_READ) begin
            old_q <= bus.mem_rdata;
            if (!we_q)
                rdata_q <= load_data;
        end
    end

endmodule
